// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-phase issue controller sitting between a requester and an
// external combinational ALU. It owns the 16x16 register file, stages operands
// into registered ALU inputs, captures the result and flags, and writes back.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [3:0]  req_rdest,
   input  logic [3:0]  req_rsrc,
   input  logic        req_imm_en,
   input  logic [15:0] req_imm,
   input  logic        req_wb,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_flags,
   output logic        done,
   output logic [15:0] done_result,
   output logic [15:0] psr,
   input  logic [3:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 4;
   localparam int unsigned OPW  = 4;
   localparam int unsigned NREG = 16;
   localparam int unsigned FW   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  rdest;
      logic [AW-1:0]  rsrc;
      logic           imm_en;
      logic [DW-1:0]  imm;
      logic           wb;
   } req_t;

   state_t         state;
   req_t           req_q;
   logic [FW-1:0]  flags_q;
   logic [FW-1:0]  psr_flags;
   logic [DW-1:0]  regs [NREG];
   logic           unused_flags;

   // Only the low flag bits are architectural; the rest of the ALU vector is dropped.
   assign unused_flags = ^alu_flags[DW-1:FW];

   // Handshake and write-back strobe are blanked while reset is held so an
   // in-flight WB never shows a pulse and no request is offered under reset.
   assign req_ready = (state == IDLE) && !reset;
   assign done      = (state == WB) && !reset;

   assign psr      = {{(DW-FW){1'b0}}, psr_flags};
   assign dbg_data = regs[dbg_addr];

   // Issue FSM: accept -> operand read -> result capture -> write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req_q       <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         done_result <= '0;
         flags_q     <= '0;
         psr_flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q.op     <= req_op;
                  req_q.rdest  <= req_rdest;
                  req_q.rsrc   <= req_rsrc;
                  req_q.imm_en <= req_imm_en;
                  req_q.imm    <= req_imm;
                  req_q.wb     <= req_wb;
                  state        <= READ;
               end
            end
            READ: begin
               alu_a  <= regs[req_q.rdest];
               alu_b  <= req_q.imm_en ? req_q.imm : regs[req_q.rsrc];
               alu_op <= req_q.op;
               state  <= EXEC;
            end
            EXEC: begin
               done_result <= alu_result;
               flags_q     <= alu_flags[FW-1:0];
               state       <= WB;
            end
            WB: begin
               psr_flags <= flags_q;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register file: cleared by reset, written from the captured result in WB.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if ((state == WB) && req_q.wb) begin
         regs[req_q.rdest] <= done_result;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_result/alu_flags, a
// register-file model predicts results, flags and write-backs.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [3:0]  req_rdest;
   logic [3:0]  req_rsrc;
   logic        req_imm_en;
   logic [15:0] req_imm;
   logic        req_wb;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_result;
   logic [15:0] alu_flags;
   logic        done;
   logic [15:0] done_result;
   logic [15:0] psr;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [31:0] alu_out;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_regs [16];

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic        ie;
      logic [15:0] imm;
      logic        wb;
      logic [15:0] res;
      logic [15:0] psr;
      logic [15:0] reg_after;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rdest(req_rdest), .req_rsrc(req_rsrc),
      .req_imm_en(req_imm_en), .req_imm(req_imm), .req_wb(req_wb),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .done(done), .done_result(done_result), .psr(psr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Reference ALU: returns {flags, result}. Flags: bit0 C, bit2 V, bit3 Z, bit4 N;
   // upper flag bits carry junk that must never reach psr.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'h0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0];
            c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'h8: begin
            r = a - b;
            c = (a >= b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'h1:    r = a & b;
         4'h2:    r = a | b;
         4'h3:    r = a ^ b;
         default: r = b;
      endcase
      return {~r[10:0], r[15], (r == 16'h0000), v, 1'b0, c, r};
   endfunction

   assign alu_out    = alu_fn(alu_op, alu_a, alu_b);
   assign alu_result = alu_out[15:0];
   assign alu_flags  = alu_out[31:16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, follow it through the pipeline and check latency, result,
   // psr and register contents; the model is then updated with the expectation.
   task automatic run_op(input string nm, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic ie, input logic [15:0] imm,
                         input logic wb, input logic [15:0] exp_res,
                         input logic [15:0] exp_psr, input logic [15:0] exp_reg);
      int w = 0;
      req_valid  = 1'b1;
      req_op     = op;
      req_rdest  = rd;
      req_rsrc   = rs;
      req_imm_en = ie;
      req_imm    = imm;
      req_wb     = wb;
      #1;
      while (!req_ready && w < 8) begin
         tick();
         w++;
      end
      chk($sformatf("%s accept", nm), 32'(req_ready), 32'd1);
      tick();
      req_valid  = 1'b0;
      req_op     = 4'($urandom);
      req_rdest  = 4'($urandom);
      req_rsrc   = 4'($urandom);
      req_imm_en = 1'($urandom);
      req_imm    = 16'($urandom);
      req_wb     = 1'($urandom);
      #1;
      chk($sformatf("%s done N+1", nm), 32'(done), 32'd0);
      tick();
      chk($sformatf("%s done N+2", nm), 32'(done), 32'd0);
      tick();
      chk($sformatf("%s done N+3", nm), 32'(done), 32'd1);
      chk($sformatf("%s result", nm), 32'(done_result), 32'(exp_res));
      dbg_addr = rd;
      tick();
      chk($sformatf("%s done N+4", nm), 32'(done), 32'd0);
      chk($sformatf("%s ready N+4", nm), 32'(req_ready), 32'd1);
      chk($sformatf("%s psr", nm), 32'(psr), 32'(exp_psr));
      chk($sformatf("%s reg", nm), 32'(dbg_data), 32'(exp_reg));
      m_regs[rd] = exp_reg;
   endtask

   // Predict an op from the model state and run it.
   task automatic model_op(input string nm, input logic [3:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic ie, input logic [15:0] imm,
                           input logic wb);
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] o;
      a = m_regs[rd];
      b = ie ? imm : m_regs[rs];
      o = alu_fn(op, a, b);
      run_op(nm, op, rd, rs, ie, imm, wb, o[15:0], {11'b0, o[20:16]},
             wb ? o[15:0] : m_regs[rd]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  ops [6];
      logic [15:0] exp16;
      logic [31:0] o;
      int acc;

      //             op    rd    rs    ie    imm       wb    res       psr       reg_after
      tbl[0] = '{4'h0, 4'h1, 4'h0, 1'b1, 16'h0005, 1'b1, 16'h0005, 16'h0000, 16'h0005};
      tbl[1] = '{4'h0, 4'h2, 4'h0, 1'b1, 16'h0005, 1'b1, 16'h0005, 16'h0000, 16'h0005};
      tbl[2] = '{4'h8, 4'h1, 4'h2, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0009, 16'h0005};
      tbl[3] = '{4'h0, 4'h3, 4'h0, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 16'h0000, 16'h7FFF};
      tbl[4] = '{4'h0, 4'h3, 4'h0, 1'b1, 16'h0001, 1'b1, 16'h8000, 16'h0014, 16'h8000};
      tbl[5] = '{4'h0, 4'h2, 4'h2, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h0000, 16'h000A};
      tbl[6] = '{4'h3, 4'h1, 4'h1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0008, 16'h0000};
      tbl[7] = '{4'h1, 4'h2, 4'h0, 1'b1, 16'h00F3, 1'b0, 16'h0002, 16'h0000, 16'h000A};

      ops[0] = 4'h0; ops[1] = 4'h8; ops[2] = 4'h1;
      ops[3] = 4'h2; ops[4] = 4'h3; ops[5] = 4'h5;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = 4'h0;
      req_rdest  = 4'h0;
      req_rsrc   = 4'h0;
      req_imm_en = 1'b0;
      req_imm    = 16'h0000;
      req_wb     = 1'b0;
      dbg_addr   = 4'h0;
      model_reset();

      // Reset held for two edges: no handshake, no done.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("rst ready c%0d", i), 32'(req_ready), 32'd0);
         chk($sformatf("rst done c%0d", i), 32'(done), 32'd0);
      end
      reset = 1'b0;
      #1;
      chk("post-rst ready", 32'(req_ready), 32'd1);
      chk("post-rst done", 32'(done), 32'd0);
      chk("post-rst psr", 32'(psr), 32'd0);
      chk("post-rst alu_a", 32'(alu_a), 32'd0);
      chk("post-rst alu_b", 32'(alu_b), 32'd0);
      chk("post-rst alu_op", 32'(alu_op), 32'd0);
      chk("post-rst done_result", 32'(done_result), 32'd0);
      chk("post-rst r0", 32'(dbg_data), 32'd0);

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie,
                tbl[i].imm, tbl[i].wb, tbl[i].res, tbl[i].psr, tbl[i].reg_after);
      end

      // req_valid held 12 cycles: one accept every 4 cycles.
      req_valid  = 1'b1;
      req_op     = 4'h0;
      req_rdest  = 4'h4;
      req_rsrc   = 4'h0;
      req_imm_en = 1'b1;
      req_imm    = 16'h0001;
      req_wb     = 1'b1;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         chk($sformatf("b2b ready c%0d", i), 32'(req_ready), 32'((i % 4) == 0));
         if (req_ready) acc++;
         tick();
      end
      req_valid = 1'b0;
      dbg_addr  = 4'h4;
      #1;
      chk("b2b accepts", 32'(acc), 32'd3);
      chk("b2b r4", 32'(dbg_data), 32'h0003);
      chk("b2b psr", 32'(psr), 32'h0000);
      m_regs[4] = 16'h0003;

      // Requests in READ/EXEC/WB are ignored.
      o = alu_fn(4'h0, m_regs[7], 16'h0011);
      req_valid = 1'b1;
      req_rdest = 4'h7;
      req_imm   = 16'h0011;
      #1;
      chk("ign accept", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         req_rdest = 4'(8 + i);
         req_imm   = 16'(16'h0022 + i);
         #1;
         chk($sformatf("ign ready s%0d", i), 32'(req_ready), 32'd0);
      end
      chk("ign done", 32'(done), 32'd1);
      chk("ign result", 32'(done_result), 32'(o[15:0]));
      tick();
      req_valid = 1'b0;
      m_regs[7] = o[15:0];
      chk("ign psr", 32'(psr), 32'({11'b0, o[20:16]}));
      for (int i = 7; i < 11; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("ign r%0d", i), 32'(dbg_data), 32'(m_regs[i]));
      end

      // Randomized ops against the model.
      for (int i = 0; i < 30; i++) begin
         model_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 5)], 4'($urandom),
                  4'($urandom), 1'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Reset during EXEC aborts the op.
      req_valid  = 1'b1;
      req_op     = 4'h0;
      req_rdest  = 4'h6;
      req_imm_en = 1'b1;
      req_imm    = 16'h0009;
      req_wb     = 1'b1;
      #1;
      chk("abrt accept", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("abrt rst done", 32'(done), 32'd0);
      chk("abrt rst ready", 32'(req_ready), 32'd0);
      tick();
      reset = 1'b0;
      model_reset();
      #1;
      chk("abrt done", 32'(done), 32'd0);
      chk("abrt ready", 32'(req_ready), 32'd1);
      chk("abrt psr", 32'(psr), 32'd0);
      chk("abrt done_result", 32'(done_result), 32'd0);
      chk("abrt alu_a", 32'(alu_a), 32'd0);
      chk("abrt alu_b", 32'(alu_b), 32'd0);
      chk("abrt alu_op", 32'(alu_op), 32'd0);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("abrt r%0d", i), 32'(dbg_data), 32'(m_regs[i]));
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("abrt idle done c%0d", i), 32'(done), 32'd0);
      end

      // Reset during WB: no pulse, no write-back, psr cleared.
      model_op("pre-wbrst", 4'h8, 4'h5, 4'h0, 1'b1, 16'h0001, 1'b1);
      exp16 = 16'h0000;
      req_valid  = 1'b1;
      req_op     = 4'h0;
      req_rdest  = 4'h5;
      req_imm_en = 1'b1;
      req_imm    = 16'h0005;
      req_wb     = 1'b1;
      #1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("wbrst done", 32'(done), 32'd0);
      tick();
      reset    = 1'b0;
      dbg_addr = 4'h5;
      #1;
      chk("wbrst psr", 32'(psr), 32'(exp16));
      chk("wbrst r5", 32'(dbg_data), 32'(exp16));
      chk("wbrst after done", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
